// File: rtl/reg_scoreboard.sv
// Register write scoreboard: counts in-flight writes per architectural register
// and raises a combinational stall on read-after-write or counter-overflow hazards.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic             issue_wr_en_i,
  input  logic [AW-1:0]    issue_dest_i,
  input  logic             issue_use_a_i,
  input  logic [AW-1:0]    issue_src_a_i,
  input  logic             issue_use_b_i,
  input  logic [AW-1:0]    issue_src_b_i,
  input  logic             wb_valid_i,
  input  logic [AW-1:0]    wb_dest_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [NREGS-1:0] busy_vec_o,
  output logic             wb_underflow_o
);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] eff   [NREGS];
  logic [NREGS-1:0] wb_rel;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             underflow_q, underflow_d;
  logic             raw, ovf, stall, accept, underflow_hit;

  // A same-cycle writeback is subtracted before the hazard checks because the
  // register file writes before it reads.
  always_comb begin
    wb_rel = '0;
    for (int r = 0; r < NREGS; r++) begin
      wb_rel[r] = wb_valid_i && (wb_dest_i == AW'(r)) && (r != 0) && (cnt_q[r] != '0);
      eff[r]    = cnt_q[r] - CNT_W'(wb_rel[r]);
    end

    raw = issue_valid_i &
          ((issue_use_a_i & (issue_src_a_i != '0) & (eff[issue_src_a_i] != '0)) |
           (issue_use_b_i & (issue_src_b_i != '0) & (eff[issue_src_b_i] != '0)));
    ovf = issue_valid_i & issue_wr_en_i & (issue_dest_i != '0) &
          (eff[issue_dest_i] == {CNT_W{1'b1}});

    stall         = (raw | ovf) & ~flush_i;
    accept        = issue_valid_i & ~stall & ~flush_i & issue_wr_en_i & (issue_dest_i != '0);
    underflow_hit = wb_valid_i & ~flush_i & (wb_dest_i != '0) & (cnt_q[wb_dest_i] == '0);
    underflow_d   = underflow_q | underflow_hit;

    busy_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = '0;
      if (!flush_i && r != 0)
        cnt_d[r] = eff[r] + CNT_W'(accept && (issue_dest_i == AW'(r)));
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '{default: '0};
      busy_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
    end
  end

  assign stall_o        = stall;
  assign busy_vec_o     = busy_q;
  assign wb_underflow_o = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios followed by
// randomized traffic compared against a per-register pending-count model.
module tb_reg_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int MAXC  = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             issue_valid_i, issue_wr_en_i, issue_use_a_i, issue_use_b_i;
  logic [AW-1:0]    issue_dest_i, issue_src_a_i, issue_src_b_i;
  logic             wb_valid_i, flush_i;
  logic [AW-1:0]    wb_dest_i;
  logic             stall_o;
  logic [NREGS-1:0] busy_vec_o;
  logic             wb_underflow_o;

  int checkCount = 0;
  int errorCount = 0;

  int modelCnt [NREGS];
  bit modelUf;

  reg_scoreboard #(.NREGS(NREGS), .AW(AW), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_wr_en_i(issue_wr_en_i),
    .issue_dest_i(issue_dest_i), .issue_use_a_i(issue_use_a_i),
    .issue_src_a_i(issue_src_a_i), .issue_use_b_i(issue_use_b_i),
    .issue_src_b_i(issue_src_b_i), .wb_valid_i(wb_valid_i),
    .wb_dest_i(wb_dest_i), .flush_i(flush_i), .stall_o(stall_o),
    .busy_vec_o(busy_vec_o), .wb_underflow_o(wb_underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelBusy();
    logic [31:0] v = '0;
    for (int r = 1; r < NREGS; r++) v[r] = (modelCnt[r] != 0);
    return v;
  endfunction

  // Pending writes to r as the issuing instruction sees them this cycle.
  function automatic int pendingSeen(int r, bit wv, int wd);
    int p = modelCnt[r];
    if (wv && wd == r && p > 0) p--;
    return p;
  endfunction

  task automatic doReset();
    rst_i = 1'b1;
    issue_valid_i = 0; issue_wr_en_i = 0; issue_dest_i = '0;
    issue_use_a_i = 0; issue_src_a_i = '0; issue_use_b_i = 0; issue_src_b_i = '0;
    wb_valid_i = 0; wb_dest_i = '0; flush_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    foreach (modelCnt[r]) modelCnt[r] = 0;
    modelUf = 0;
    checkOutput("reset_busy", busy_vec_o, 32'h0);
    checkOutput("reset_uf", {31'b0, wb_underflow_o}, 32'h0);
  endtask

  // One cycle: drive inputs, check the combinational stall, clock, check state.
  task automatic applyStimulus(input string tag, input bit v, input bit we, input int dest,
                               input bit ua, input int sa, input bit ub, input int sb,
                               input bit wv, input int wd, input bit fl);
    bit expStall, raw, ovf, accept;
    issue_valid_i = v; issue_wr_en_i = we; issue_dest_i = AW'(dest);
    issue_use_a_i = ua; issue_src_a_i = AW'(sa);
    issue_use_b_i = ub; issue_src_b_i = AW'(sb);
    wb_valid_i = wv; wb_dest_i = AW'(wd); flush_i = fl;
    #1;
    raw = v && ((ua && sa != 0 && pendingSeen(sa, wv, wd) > 0) ||
                (ub && sb != 0 && pendingSeen(sb, wv, wd) > 0));
    ovf = v && we && dest != 0 && pendingSeen(dest, wv, wd) == MAXC;
    expStall = (raw || ovf) && !fl;
    checkOutput({tag, "_stall"}, {31'b0, stall_o}, {31'b0, expStall});
    accept = v && !expStall && !fl && we && dest != 0;
    @(posedge clk_i); #1;
    if (fl) begin
      foreach (modelCnt[r]) modelCnt[r] = 0;
    end else begin
      if (wv && wd != 0) begin
        if (modelCnt[wd] > 0) modelCnt[wd]--;
        else modelUf = 1;
      end
      if (accept) modelCnt[dest]++;
    end
    checkOutput({tag, "_busy"}, busy_vec_o, modelBusy());
    checkOutput({tag, "_uf"}, {31'b0, wb_underflow_o}, {31'b0, modelUf});
  endtask

  initial begin
    doReset();

    // 1: write r8 then read r8
    applyStimulus("t1_issue", 1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_busy8", {31'b0, busy_vec_o[8]}, 32'h1);
    applyStimulus("t1_read", 1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    checkOutput("t1_stall_const", {31'b0, stall_o}, 32'h1);

    // 2: writeback of r8 releases same-cycle reader
    applyStimulus("t2", 1, 0, 0, 1, 8, 0, 0, 1, 8, 0);
    checkOutput("t2_busy8", {31'b0, busy_vec_o[8]}, 32'h0);

    // 3: counter saturation on r9
    for (int i = 0; i < 3; i++) applyStimulus("t3_fill", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t3_ovf", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_cnt9", 32'(modelCnt[9]), 32'd3);

    // 4: issue and writeback of r5 cancel
    applyStimulus("t4_a", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t4_b", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t4_both", 1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    checkOutput("t4_cnt5", 32'(modelCnt[5]), 32'd2);

    // 5: flush clears everything and overrides a hazard
    applyStimulus("t5_r3", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t5_r7", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("t5_flush", 1, 1, 4, 1, 3, 1, 7, 0, 0, 1);
    checkOutput("t5_busy_zero", busy_vec_o, 32'h0);

    // 6: underflow is sticky; r0 never hazards
    applyStimulus("t6_uf", 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    checkOutput("t6_uf_set", {31'b0, wb_underflow_o}, 32'h1);
    applyStimulus("t6_r0", 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus("t6_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_uf_hold", {31'b0, wb_underflow_o}, 32'h1);
    applyStimulus("t6_wb0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    doReset();

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      applyStimulus("rnd",
                    bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                    bit'($urandom_range(0, 9) < 4), int'($urandom_range(0, 6)),
                    bit'($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
